// File: rtl/ppa_pkg.sv
// Shared constants and types for the 16-bit Kogge-Stone adder slice.
// Optional input register stage is enabled with `define PPA_IN_REG_EN.
package ppa_pkg;

  localparam int PPA_WIDTH = 16;
  localparam int LEVELS    = $clog2(PPA_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_bit(input logic a, input logic b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/ppa_if.sv
// Operand/result bundle for ppa_16; master drives operands, slave returns the sum.
interface ppa_if
  import ppa_pkg::*;
#(
  parameter int WIDTH = PPA_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (output A, output B, output Cin, input S, input Cout);
  modport slave  (input A, input B, input Cin, output S, output Cout);

endinterface

// File: rtl/ppa_gp_cell.sv
// Kogge-Stone prefix operator: merges a high group with the adjacent low group.
module ppa_gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/ppa_16.sv
// Registered Kogge-Stone parallel-prefix adder with carry-in as prefix position -1.
// Defining PPA_IN_REG_EN adds a reset-to-zero register stage on A, B and Cin.
module ppa_16
  import ppa_pkg::*;
#(
  parameter int WIDTH = PPA_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  ppa_if.slave bus
);

  localparam int LVL = $clog2(WIDTH);

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic             cin_op;

`ifdef PPA_IN_REG_EN
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
    end else begin
      a_reg   <= bus.A;
      b_reg   <= bus.B;
      cin_reg <= bus.Cin;
    end
  end

  assign a_op   = a_reg;
  assign b_op   = b_reg;
  assign cin_op = cin_reg;
`else
  assign a_op   = bus.A;
  assign b_op   = bus.B;
  assign cin_op = bus.Cin;
`endif

  gp_t bit_gp [WIDTH];
  // node[l][j]: group (g,p) after level l at prefix position j, where
  // position 0 is the carry-in and position j>0 is operand bit j-1.
  gp_t node [LVL+1][WIDTH];

  logic [WIDTH-1:0] s_next;
  logic             cout_next;
  logic             cout_p;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  genvar gi;
  genvar gl;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      assign bit_gp[gi] = gp_bit(a_op[gi], b_op[gi]);
    end

    assign node[0][0] = '{g: cin_op, p: 1'b0};
    for (gi = 1; gi < WIDTH; gi++) begin : g_seed
      assign node[0][gi] = bit_gp[gi-1];
    end

    for (gl = 1; gl <= LVL; gl++) begin : g_lvl
      for (gi = 0; gi < WIDTH; gi++) begin : g_node
        if (gi >= (1 << (gl - 1))) begin : g_cell
          logic cg;
          logic cp;
          ppa_gp_cell u_cell (
            .g_hi (node[gl-1][gi].g),
            .p_hi (node[gl-1][gi].p),
            .g_lo (node[gl-1][gi - (1 << (gl - 1))].g),
            .p_lo (node[gl-1][gi - (1 << (gl - 1))].p),
            .g    (cg),
            .p    (cp)
          );
          assign node[gl][gi] = '{g: cg, p: cp};
        end else begin : g_pass
          assign node[gl][gi] = node[gl-1][gi];
        end
      end
    end

    // After LVL levels node[LVL][i].g spans bits i-1..-1, i.e. the carry into bit i.
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign s_next[gi] = bit_gp[gi].p ^ node[LVL][gi].g;
    end
  endgenerate

  // The top bit needs one extra merge to span WIDTH-1..-1 for the carry-out.
  ppa_gp_cell u_cout (
    .g_hi (bit_gp[WIDTH-1].g),
    .p_hi (bit_gp[WIDTH-1].p),
    .g_lo (node[LVL][WIDTH-1].g),
    .p_lo (node[LVL][WIDTH-1].p),
    .g    (cout_next),
    .p    (cout_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      s_reg    <= s_next;
      cout_reg <= cout_next;
    end
  end

  assign bus.S    = s_reg;
  assign bus.Cout = cout_reg;

endmodule

// File: tb/tb_ppa_16.sv
// Directed and random self-checking bench for ppa_16 (either PPA_IN_REG_EN setting).
module tb_ppa_16;

  localparam int W = 16;
`ifdef PPA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NRAND = 10000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ppa_if #(.WIDTH(W)) bus ();

  ppa_16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] va   [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h1234, 16'hAAAA, 16'hFFFF};
  logic [W-1:0] vb   [6] = '{16'h0000, 16'h0002, 16'h0001, 16'h5678, 16'h5555, 16'hFFFF};
  logic         vc   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W:0]   vexp [6] = '{17'h0_0000, 17'h0_0003, 17'h1_0000, 17'h0_68AC, 17'h1_0000, 17'h1_FFFF};

  task automatic test_reset();
    rst_n   = 1'b1;
    bus.A   = 16'h1234;
    bus.B   = 16'h1111;
    bus.Cin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", {bus.Cout, bus.S}, 17'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL reset_held got=%h want=%h", {bus.Cout, bus.S}, 17'h0);
    end
    $display("txn reset cout_s=%h", {bus.Cout, bus.S});
    @(negedge clk);
    rst_n   = 1'b1;
    bus.A   = '0;
    bus.B   = '0;
    bus.Cin = 1'b0;
    repeat (LAT) @(posedge clk);
  endtask

  task automatic test_directed();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.A   = va[i];
      bus.B   = vb[i];
      bus.Cin = vc[i];
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if ({bus.Cout, bus.S} !== vexp[i]) begin
        errors++;
        $display("FAIL directed_%0d got=%h want=%h", i, {bus.Cout, bus.S}, vexp[i]);
      end
      $display("txn directed %0d a=%h b=%h cin=%b cout_s=%h", i, va[i], vb[i], vc[i], {bus.Cout, bus.S});
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    @(negedge clk);
    for (int k = 0; k < 6 + LAT - 1; k++) begin
      if (k < 6) begin
        bus.A   = va[5-k];
        bus.B   = vb[5-k];
        bus.Cin = vc[5-k];
      end
      @(posedge clk);
      #1;
      idx = k - LAT + 1;
      if (idx >= 0) begin
        checks++;
        if ({bus.Cout, bus.S} !== vexp[5-idx]) begin
          errors++;
          $display("FAIL b2b_%0d got=%h want=%h", idx, {bus.Cout, bus.S}, vexp[5-idx]);
        end
        $display("txn b2b %0d cout_s=%h", idx, {bus.Cout, bus.S});
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    bus.A   = va[5];
    bus.B   = vb[5];
    bus.Cin = vc[5];
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL midrst_immediate got=%h want=%h", {bus.Cout, bus.S}, 17'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL midrst_held got=%h want=%h", {bus.Cout, bus.S}, 17'h0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.A   = va[3];
    bus.B   = vb[3];
    bus.Cin = vc[3];
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL midrst_release got=%h want=%h", {bus.Cout, bus.S}, 17'h0);
    end
    @(posedge clk);
    #1;
`ifdef PPA_IN_REG_EN
    // Input register was cleared, so the first edge computes 0+0+0.
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL midrst_flushed got=%h want=%h", {bus.Cout, bus.S}, 17'h0);
    end
    @(posedge clk);
    #1;
`endif
    checks++;
    if ({bus.Cout, bus.S} !== vexp[3]) begin
      errors++;
      $display("FAIL midrst_first got=%h want=%h", {bus.Cout, bus.S}, vexp[3]);
    end
    $display("txn midrst first cout_s=%h", {bus.Cout, bus.S});
  endtask

  task automatic test_random();
    logic [W:0] expq [$];
    logic [W:0] want;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    @(negedge clk);
    for (int k = 0; k < NRAND + LAT - 1; k++) begin
      if (k < NRAND) begin
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = c;
        expq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
      end
      @(posedge clk);
      #1;
      if (k >= LAT - 1) begin
        want = expq.pop_front();
        checks++;
        if ({bus.Cout, bus.S} !== want) begin
          errors++;
          $display("FAIL random_%0d got=%h want=%h", k - LAT + 1, {bus.Cout, bus.S}, want);
        end
        $display("txn random %0d cout_s=%h", k - LAT + 1, {bus.Cout, bus.S});
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    bus.A   = '0;
    bus.B   = '0;
    bus.Cin = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
